// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Round-robin arbiter that shares one combinational ALU between two
//   requesters. The winning request drives the ALU in the same cycle and the
//   ALU outputs are captured into a single-entry response buffer tagged with
//   the requester ID.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   reqN_valid / reqN_ready     request handshake, N = 0, 1
//   reqN_opcode/op1/op2         request payload
//   alu_opcode/op1/op2          drive to shared ALU (zeros when idle)
//   alu_result/zero/overflow    from shared ALU
//   rsp_valid / rsp_ready       response handshake
//   rsp_id, rsp_result,
//   rsp_zero, rsp_overflow      registered response
//
// Optional build macro ALU_ARB_STATS_EN adds:
//   grant_cnt0/1  (CNT_W)       per-port handshake counters, wrapping
//   ovf_sticky0/1               set on a captured overflow for that port
module alu_arbiter #(
    parameter int WIDTH = 16
`ifdef ALU_ARB_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_opcode,
    input  logic [WIDTH-1:0] req0_op1,
    input  logic [WIDTH-1:0] req0_op2,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_opcode,
    input  logic [WIDTH-1:0] req1_op1,
    input  logic [WIDTH-1:0] req1_op2,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_overflow
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1,
    output logic             ovf_sticky0,
    output logic             ovf_sticky1
`endif
);

    typedef enum logic {EMPTY, FULL} buf_state_t;

    buf_state_t state, state_nxt;
    logic       last_grant;
    logic       can_accept;
    logic       grant0, grant1;
    logic       handshake;

    assign rsp_valid = (state == FULL);

    always_comb begin
        can_accept = (state == EMPTY) | rsp_ready;
        grant0     = 1'b0;
        grant1     = 1'b0;
        alu_opcode = 4'b0000;
        alu_op1    = '0;
        alu_op2    = '0;
        state_nxt  = state;

        if (can_accept) begin
            if (req0_valid && req1_valid) begin
                // Tie: the port that did not win last time goes first.
                grant0 = last_grant;
                grant1 = ~last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
        handshake = grant0 | grant1;

        if (grant0) begin
            alu_opcode = req0_opcode;
            alu_op1    = req0_op1;
            alu_op2    = req0_op2;
        end else if (grant1) begin
            alu_opcode = req1_opcode;
            alu_op1    = req1_op1;
            alu_op2    = req1_op2;
        end

        if (handshake)
            state_nxt = FULL;
        else if (rsp_ready)
            state_nxt = EMPTY;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= EMPTY;
            last_grant   <= 1'b1;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (handshake) begin
                rsp_id       <= grant1;
                rsp_result   <= alu_result;
                rsp_zero     <= alu_zero;
                rsp_overflow <= alu_overflow;
                last_grant   <= grant1;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0  <= '0;
            grant_cnt1  <= '0;
            ovf_sticky0 <= 1'b0;
            ovf_sticky1 <= 1'b0;
        end else begin
            if (grant0) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            if (grant1) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            if (grant0 && alu_overflow) ovf_sticky0 <= 1'b1;
            if (grant1 && alu_overflow) ovf_sticky1 <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a small behavioural ALU attached.
module tb_alu_arbiter;

    localparam int WIDTH = 16;
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADD1 = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h9;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready;
    logic [3:0]       req0_opcode;
    logic [WIDTH-1:0] req0_op1, req0_op2;
    logic             req1_valid, req1_ready;
    logic [3:0]       req1_opcode;
    logic [WIDTH-1:0] req1_op1, req1_op2;
    logic [3:0]       alu_opcode;
    logic [WIDTH-1:0] alu_op1, alu_op2, alu_result;
    logic             alu_zero, alu_overflow;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero, rsp_overflow;
`ifdef ALU_ARB_STATS_EN
    logic [15:0]      grant_cnt0, grant_cnt1;
    logic             ovf_sticky0, ovf_sticky1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_op1(req1_op1), .req1_op2(req1_op2),
        .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
        .ovf_sticky0(ovf_sticky0), .ovf_sticky1(ovf_sticky1)
`endif
    );

    // Minimal shared ALU: add, add-one, xor; anything else passes op1.
    always_comb begin
        alu_overflow = 1'b0;
        case (alu_opcode)
            OP_ADD: begin
                alu_result   = alu_op1 + alu_op2;
                alu_overflow = (alu_op1[WIDTH-1] == alu_op2[WIDTH-1]) &&
                               (alu_result[WIDTH-1] != alu_op1[WIDTH-1]);
            end
            OP_ADD1: begin
                alu_result   = alu_op1 + 16'h0001;
                alu_overflow = (alu_op1 == 16'h7FFF);
            end
            OP_XOR:  alu_result = alu_op1 ^ alu_op2;
            default: alu_result = alu_op1;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_opcode = '0; req0_op1 = '0; req0_op2 = '0;
        req1_valid = 1'b0; req1_opcode = '0; req1_op1 = '0; req1_op2 = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_valid", rsp_valid, 0);
        check("rst_id", rsp_id, 0);
        check("rst_result", rsp_result, 0);
        check("rst_zero", rsp_zero, 0);
        check("rst_ovf", rsp_overflow, 0);
`ifdef ALU_ARB_STATS_EN
        check("rst_cnt0", grant_cnt0, 0);
        check("rst_cnt1", grant_cnt1, 0);
`endif

        // Single request on port 0: 3 + 4
        req0_valid = 1'b1; req0_opcode = OP_ADD; req0_op1 = 16'h0003; req0_op2 = 16'h0004;
        rsp_ready = 1'b1;
        #1;
        check("single_ready0", req0_ready, 1);
        check("single_ready1", req1_ready, 0);
        check("single_alu_op1", alu_op1, 16'h0003);
        check("single_alu_op2", alu_op2, 16'h0004);
        tick();
        req0_valid = 1'b0;
        check("single_valid", rsp_valid, 1);
        check("single_id", rsp_id, 0);
        check("single_result", rsp_result, 16'h0007);
        check("single_zero", rsp_zero, 0);
        check("single_ovf", rsp_overflow, 0);

        // Overflow on port 1: 7FFF + 0001
        req1_valid = 1'b1; req1_opcode = OP_ADD; req1_op1 = 16'h7FFF; req1_op2 = 16'h0001;
        #1;
        check("ovf_ready1", req1_ready, 1);
        tick();
        check("ovf_id", rsp_id, 1);
        check("ovf_result", rsp_result, 16'h8000);
        check("ovf_flag", rsp_overflow, 1);
        check("ovf_zero", rsp_zero, 0);
`ifdef ALU_ARB_STATS_EN
        check("ovf_sticky1", ovf_sticky1, 1);
        check("ovf_sticky0", ovf_sticky0, 0);
        check("ovf_cnt1", grant_cnt1, 1);
        check("ovf_cnt0", grant_cnt0, 1);
`endif

        // Round robin with both ports valid every cycle
        req0_valid = 1'b1; req0_opcode = OP_XOR;  req0_op1 = 16'hFFFF; req0_op2 = 16'hFFFF;
        req1_valid = 1'b1; req1_opcode = OP_ADD1; req1_op1 = 16'h0010; req1_op2 = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
            check("rr_ready1", req1_ready, (i % 2 == 1) ? 1 : 0);
            tick();
            check("rr_id", rsp_id, i % 2);
            check("rr_result", rsp_result, (i % 2 == 0) ? 16'h0000 : 16'h0011);
            check("rr_zero", rsp_zero, (i % 2 == 0) ? 1 : 0);
        end

        // Backpressure: response from port 1 (0011) held for 5 cycles
        rsp_ready = 1'b0;
        #1;
        check("bp_ready0", req0_ready, 0);
        check("bp_ready1", req1_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", rsp_valid, 1);
            check("bp_id", rsp_id, 1);
            check("bp_result", rsp_result, 16'h0011);
            check("bp_hold_ready", req0_ready | req1_ready, 0);
        end
        rsp_ready = 1'b1;
        #1;
        check("refill_ready0", req0_ready, 1);
        check("refill_ready1", req1_ready, 0);
        tick();
        check("refill_valid", rsp_valid, 1);
        check("refill_id", rsp_id, 0);
        check("refill_result", rsp_result, 16'h0000);
`ifdef ALU_ARB_STATS_EN
        check("refill_cnt0", grant_cnt0, 4);
        check("refill_cnt1", grant_cnt1, 3);
`endif

        // Idle drive and drain
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check("idle_opcode", alu_opcode, 0);
        check("idle_op1", alu_op1, 0);
        check("idle_op2", alu_op2, 0);
        check("idle_ready0", req0_ready, 0);
        check("idle_ready1", req1_ready, 0);
        check("idle_valid_before", rsp_valid, 1);
        tick();
        check("drain_valid", rsp_valid, 0);
        check("drain_hold_zero", rsp_zero, 1);
        check("drain_hold_id", rsp_id, 0);

        // Reset mid-operation: leave last_grant at 0, then hold a response
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_opcode = OP_ADD; req0_op1 = 16'h0001; req0_op2 = 16'h0002;
        tick();
        req0_valid = 1'b0;
        check("pre_rst_valid", rsp_valid, 1);
        check("pre_rst_result", rsp_result, 16'h0003);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_result", rsp_result, 0);
`ifdef ALU_ARB_STATS_EN
        check("mid_rst_cnt0", grant_cnt0, 0);
        check("mid_rst_cnt1", grant_cnt1, 0);
        check("mid_rst_sticky1", ovf_sticky1, 0);
`endif
        req0_valid = 1'b1; req0_opcode = OP_ADD; req0_op1 = 16'h0005; req0_op2 = 16'h0005;
        req1_valid = 1'b1; req1_opcode = OP_ADD; req1_op1 = 16'h0009; req1_op2 = 16'h0009;
        #1;
        check("post_rst_tie0", req0_ready, 1);
        check("post_rst_tie1", req1_ready, 0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("post_rst_id", rsp_id, 0);
        check("post_rst_result", rsp_result, 16'h000A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU instance between two requesters, e.g. the CPU execute stage (port 0) and an address/loop-counter unit (port 1).
- Arbitration is round-robin with a valid/ready handshake on each request port.
- The block drives the ALU's opcode/op1/op2 inputs and captures result/equals_zero/overflow into a single-entry response buffer.
- The response buffer is tagged with the winning requester's ID.

Parameters:
- WIDTH, 16, operand/result width; must match the shared ALU's WIDTH.
- CNT_W, 16, width of the per-port grant counters (optional feature only).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  port 0 has a request
- req0_ready  output  1  port 0 request accepted this cycle
- req0_opcode  input  4  port 0 ALU opcode (full 16-op encoding, all legal)
- req0_op1  input  WIDTH  port 0 operand 1
- req0_op2  input  WIDTH  port 0 operand 2
- req1_valid  input  1  port 1 has a request
- req1_ready  output  1  port 1 request accepted this cycle
- req1_opcode  input  4  port 1 opcode
- req1_op1  input  WIDTH  port 1 operand 1
- req1_op2  input  WIDTH  port 1 operand 2
- alu_opcode  output  4  to shared ALU
- alu_op1  output  WIDTH  to shared ALU
- alu_op2  output  WIDTH  to shared ALU
- alu_result  input  WIDTH  from shared ALU
- alu_zero  input  1  from ALU equals_zero
- alu_overflow  input  1  from ALU overflow
- rsp_valid  output  1  response buffer full
- rsp_ready  input  1  consumer takes response
- rsp_id  output  1  requester that owns the response (0/1)
- rsp_result  output  WIDTH  registered ALU result
- rsp_zero  output  1  registered equals_zero
- rsp_overflow  output  1  registered overflow

Behaviour:
- Reset (rst=1 at a clk edge):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_overflow=0.
  - last_grant=1, so port 0 wins the first tie.
  - Reset aborts any held response; it is dropped and not replayed.
- Buffer states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = !rsp_valid | rsp_ready (drain and refill in the same cycle is allowed).
- Grant is combinational, in the same cycle:
  - If can_accept=0: no grant.
  - Only one valid: that port is granted.
  - Both valid: the port != last_grant is granted.
  - reqN_ready = grant to port N; at most one ready is high per cycle.
  - Handshake completes on reqN_valid & reqN_ready.
- ALU drive:
  - With a grant: alu_* = the granted port's opcode/op1/op2.
  - With no grant: alu_opcode=4'b0000, alu_op1=0, alu_op2=0 (no X/Z on the ALU inputs).
- Capture on a handshake edge:
  - rsp_result/rsp_zero/rsp_overflow <= alu_* inputs; rsp_id <= granted port.
  - rsp_valid <= 1; last_grant <= granted port.
- Drain: rsp_valid & rsp_ready with no new handshake gives rsp_valid <= 0. Data outputs hold their last values.
- Latency: request accepted in cycle N, response visible in cycle N+1. Sustained throughput is 1 op/cycle when rsp_ready is held high.
- Backpressure:
  - rsp_valid=1 and rsp_ready=0 gives both readies=0.
  - All rsp_* outputs stay stable until taken.
- Requesters hold opcode/operands stable while valid & !ready. The arbiter does not latch unaccepted requests.
- last_grant changes only on a handshake. A port that drops valid without being granted does not lose priority.
- Fairness: with both ports continuously valid and the consumer always ready, grants alternate 0,1,0,1,...
- Overflow/zero are passed through from the ALU unmodified. For logic and shift opcodes overflow is whatever the ALU reports (0).

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds output ports grant_cnt0 and grant_cnt1, each CNT_W bits.
  - Each counter increments by 1 on every handshake of its port and wraps modulo 2^CNT_W.
  - Also adds output ovf_sticky0/ovf_sticky1 (1 bit): set when that port's captured response has overflow=1, cleared only by rst.
  - All of these reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then single request: rst high 2 cycles; req0 add op1=16'h0003 op2=16'h0004, rsp_ready=1.
  - req0_ready=1 in cycle N.
  - Cycle N+1: rsp_valid=1, rsp_id=0, rsp_result=16'h0007, rsp_zero=0, rsp_overflow=0.
- Tie and round-robin: both valid every cycle; port0 xor 16'hFFFF^16'hFFFF, port1 add1 16'h0010; rsp_ready=1.
  - Grants go 0,1,0,1.
  - Port 0 responses: result=0, zero=1. Port 1 responses: result=16'h0011.
- Backpressure: rsp_ready=0 after first capture.
  - Both readies stay 0; rsp_* stay constant for 5 cycles.
  - Raising rsp_ready gives a same-cycle refill; the next response follows the very next cycle.
- Overflow: port1 add 16'h7FFF + 16'h0001.
  - rsp_result=16'h8000, rsp_overflow=1, rsp_id=1.
  - With ALU_ARB_STATS_EN: ovf_sticky1=1, grant_cnt1 increments.
- Idle drive: no valid inputs; check alu_opcode=0, alu_op1=0, alu_op2=0, both readies 0, rsp_valid falls after the drain.
- Reset mid-operation: rst asserted while rsp_valid=1 and rsp_ready=0.
  - Next cycle rsp_valid=0, last_grant=1.
  - A subsequent tie is granted to port 0; counters are 0 when the feature is enabled.
